// File: rtl/mig_pkg.sv
// Shared types and constants for the majority-inverter network truth-table sweeper.
package mig_pkg;

    localparam int NUM_IN    = 7;
    localparam int MAX_NODES = 8;
    localparam int SIG_W     = 4;
    localparam int NUM_PAT   = 1 << NUM_IN;

    // Signal space: 0 = const0, 1..7 = x0..x6, 8..15 = node 0..7
    localparam logic [SIG_W-1:0] CONST0_IDX = 4'd0;
    localparam logic [SIG_W-1:0] X_BASE     = 4'd1;
    localparam logic [SIG_W-1:0] NODE_BASE  = 4'd8;

    typedef struct packed {
        logic             inv;
        logic [SIG_W-1:0] idx;
    } operand_t;

    typedef struct packed {
        operand_t a;
        operand_t b;
        operand_t c;
    } node_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAL  = 2'd1,
        STORE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Index of the last active node: a count of 0 runs one node, >MAX_NODES runs all.
    function automatic logic [2:0] clamp_last(input logic [3:0] n);
        if (n == 4'd0) return 3'd0;
        if (n >= 4'(MAX_NODES)) return 3'(MAX_NODES - 1);
        return 3'(n - 4'd1);
    endfunction

endpackage

// File: rtl/mig_truth_table_sweeper_maj3_unit.sv
// Three-input majority gate with an optional complement on each operand.
module maj3_unit (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic ia,
    input  logic ib,
    input  logic ic,
    output logic y
);
    logic ta, tb, tc;

    assign ta = a ^ ia;
    assign tb = b ^ ib;
    assign tc = c ^ ic;
    assign y  = (ta & tb) | (ta & tc) | (tb & tc);

endmodule

// File: rtl/mig_truth_table_sweeper.sv
// Sweeps all 128 input patterns through a programmed majority-inverter network,
// evaluating one node per cycle on a single shared majority unit.
module mig_truth_table_sweeper
    import mig_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [3:0]   num_nodes,
    input  logic         out_inv,
    input  logic         cfg_we,
    input  logic [2:0]   cfg_addr,
    input  logic [14:0]  cfg_data,
    output logic         busy,
    output logic         done,
    output logic [127:0] tt,
    output logic [1:0]   dbg_state
);
    // Handshake: start is a one-cycle request taken only in IDLE; busy rises the
    // cycle after, and done pulses for one cycle (busy low) when tt is final.

    state_t                   state, state_nxt;
    logic [NUM_IN-1:0]        pat;
    logic [2:0]               k;
    logic [2:0]               last;
    logic                     inv_lat;
    node_t                    prog [MAX_NODES];
    logic [MAX_NODES-1:0]     res;
    logic [(1<<SIG_W)-1:0]    sig;
    node_t                    cur;
    logic                     maj_y;

    assign busy      = (state == EVAL) || (state == STORE);
    assign done      = (state == DONE);
    assign dbg_state = state;

    always_comb begin
        sig = '0;
        sig[CONST0_IDX]               = 1'b0;
        sig[X_BASE +: NUM_IN]         = pat;
        sig[NODE_BASE +: MAX_NODES]   = res;
    end

    assign cur = prog[k];

    maj3_unit u_maj (
        .a  (sig[cur.a.idx]),
        .b  (sig[cur.b.idx]),
        .c  (sig[cur.c.idx]),
        .ia (cur.a.inv),
        .ib (cur.b.inv),
        .ic (cur.c.inv),
        .y  (maj_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = EVAL;
            EVAL:    if (k == last) state_nxt = STORE;
            STORE:   state_nxt = (pat == 7'(NUM_PAT - 1)) ? DONE : EVAL;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat     <= '0;
            k       <= '0;
            last    <= '0;
            inv_lat <= 1'b0;
            res     <= '0;
            tt      <= '0;
            for (int i = 0; i < MAX_NODES; i++) prog[i] <= '0;
        end else begin
            // Writes in the start cycle land before the first node is read.
            if (cfg_we && !busy) prog[cfg_addr] <= cfg_data;
            case (state)
                IDLE: begin
                    if (start) begin
                        last    <= clamp_last(num_nodes);
                        inv_lat <= out_inv;
                        pat     <= '0;
                        k       <= '0;
                        res     <= '0;
                        tt      <= '0;
                    end
                end
                EVAL: begin
                    res[k] <= maj_y;
                    if (k != last) k <= k + 3'd1;
                end
                STORE: begin
                    // Clearing node results makes forward/self references read 0.
                    tt[pat] <= res[last] ^ inv_lat;
                    res     <= '0;
                    k       <= '0;
                    if (pat != 7'(NUM_PAT - 1)) pat <= pat + 7'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mig_truth_table_sweeper.sv
// Directed bench for the MIG truth-table sweeper with a behavioural network model.
module tb_mig_truth_table_sweeper;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   num_nodes = 4'd1;
    logic         out_inv = 1'b0;
    logic         cfg_we = 1'b0;
    logic [2:0]   cfg_addr = 3'd0;
    logic [14:0]  cfg_data = 15'd0;
    logic         busy, done;
    logic [127:0] tt;
    logic [1:0]   dbg_state;

    int errors = 0;
    int checks = 0;
    logic chk_en = 1'b0;

    // Model state
    logic [14:0]  m_prog [8];
    int           m_left = 0;
    logic         m_done = 1'b0;
    logic [127:0] m_tt = '0;
    logic [127:0] m_pend = '0;

    mig_truth_table_sweeper dut (
        .clk(clk), .rst(rst), .start(start), .num_nodes(num_nodes),
        .out_inv(out_inv), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .busy(busy), .done(done), .tt(tt),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] op(input logic inv, input int idx);
        return {inv, 4'(idx)};
    endfunction

    function automatic logic [14:0] nd(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
        return {a, b, c};
    endfunction

    // Evaluate the network directly from its definition for every pattern.
    function automatic logic [127:0] model_tt(input int n, input logic inv);
        logic [127:0] r;
        int v [8];
        int f, idx, val, sum;
        r = '0;
        for (int p = 0; p < 128; p++) begin
            for (int j = 0; j < 8; j++) v[j] = 0;
            for (int kk = 0; kk < n; kk++) begin
                sum = 0;
                for (int o = 0; o < 3; o++) begin
                    f   = int'(m_prog[kk] >> (10 - 5 * o)) & 31;
                    idx = f & 15;
                    if (idx == 0)     val = 0;
                    else if (idx < 8) val = (p >> (idx - 1)) & 1;
                    else              val = v[idx - 8];
                    sum += val ^ (f >> 4);
                end
                v[kk] = (sum >= 2) ? 1 : 0;
            end
            r[p] = v[n - 1][0] ^ inv;
        end
        return r;
    endfunction

    initial for (int i = 0; i < 8; i++) m_prog[i] = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left = 0;
            m_done = 1'b0;
            m_tt   = '0;
            for (int i = 0; i < 8; i++) m_prog[i] = '0;
        end else begin
            int n;
            if (cfg_we && m_left == 0) m_prog[cfg_addr] = cfg_data;
            if (m_done) m_done = 1'b0;
            else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1'b1;
                    m_tt   = m_pend;
                end
            end else if (start) begin
                n = (num_nodes == 0) ? 1 : (num_nodes > 8) ? 8 : int'(num_nodes);
                m_left = 128 * (n + 1);
                m_pend = model_tt(n, out_inv);
                m_tt   = '0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 128'(busy), 128'(m_left > 0));
            check("done", 128'(done), 128'(m_done));
            if (m_left == 0) check("tt_idle", tt, m_tt);
        end
    end

    task automatic cfg_write(input logic [2:0] a, input logic [14:0] d);
        @(posedge clk); #2;
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        @(posedge clk); #2;
        cfg_we = 1'b0;
    endtask

    task automatic run(input string name, input logic [3:0] nn, input logic inv,
                       input logic w_en, input logic [2:0] w_addr, input logic [14:0] w_data,
                       input logic perturb, input int exp_lat, input logic [127:0] exp_tt);
        int c;
        @(posedge clk); #2;
        num_nodes = nn; out_inv = inv; start = 1'b1;
        cfg_we = w_en; cfg_addr = w_addr; cfg_data = w_data;
        @(posedge clk); #2;
        start = 1'b0; cfg_we = 1'b0;
        c = 1;
        while (!done && c < 3000) begin
            @(posedge clk); #2;
            c++;
            if (perturb && c == 100) begin
                start = 1'b1; num_nodes = 4'd1; out_inv = 1'b1;
                cfg_we = 1'b1; cfg_addr = 3'd5; cfg_data = 15'd0;
            end else if (perturb && c == 101) begin
                start = 1'b0; cfg_we = 1'b0;
            end
        end
        if (!done) begin
            errors++; checks++;
            $display("FAIL %s_timeout: no done after %0d cycles, required %0d", name, c, exp_lat);
        end else begin
            check({name, "_lat"}, 128'(c), 128'(exp_lat));
            check({name, "_tt"}, tt, exp_tt);
        end
    endtask

    task automatic load_six();
        cfg_write(3'd0, nd(op(0, 2), op(0, 6), op(0, 7)));
        cfg_write(3'd1, nd(op(0, 2), op(0, 4), op(0, 5)));
        cfg_write(3'd2, nd(op(0, 2), op(0, 3), op(0, 4)));
        cfg_write(3'd3, nd(op(0, 1), op(0, 8), op(0, 9)));
        cfg_write(3'd4, nd(op(0, 3), op(0, 5), op(0, 10)));
        cfg_write(3'd5, nd(op(0, 1), op(0, 11), op(0, 12)));
    endtask

    localparam logic [127:0] TT_E8  = {16{8'hE8}};
    localparam logic [127:0] TT_8   = {32{4'h8}};
    localparam logic [127:0] TT_7   = {32{4'h7}};
    localparam logic [127:0] TT_E   = {32{4'hE}};
    localparam logic [127:0] TT_X6  = {64'hFFFFFFFFFFFFFFFF, 64'h0};
    localparam logic [127:0] TT_SIX = 128'hfeeaeaaaeee8e888eee8e888aaa8a880;

    initial begin
        #1 rst = 1'b1;
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("reset_busy", 128'(busy), 128'd0);
        check("reset_done", 128'(done), 128'd0);
        check("reset_tt", tt, 128'd0);
        check("reset_state", 128'(dbg_state), 128'd0);

        cfg_write(3'd0, nd(op(0, 1), op(0, 2), op(0, 3)));
        run("maj3", 4'd1, 1'b0, 1'b0, 3'd0, 15'd0, 1'b0, 257, TT_E8);

        cfg_write(3'd0, nd(op(0, 1), op(0, 2), op(0, 0)));
        run("and2", 4'd1, 1'b0, 1'b0, 3'd0, 15'd0, 1'b0, 257, TT_8);
        run("nand2", 4'd1, 1'b1, 1'b0, 3'd0, 15'd0, 1'b0, 257, TT_7);
        run("or2_wr_start", 4'd1, 1'b0, 1'b1, 3'd0, nd(op(0, 1), op(0, 2), op(1, 0)), 1'b0, 257, TT_E);

        cfg_write(3'd0, nd(op(0, 7), op(0, 7), op(0, 0)));
        run("x6", 4'd1, 1'b0, 1'b0, 3'd0, 15'd0, 1'b0, 257, TT_X6);

        load_six();
        run("six", 4'd6, 1'b0, 1'b0, 3'd0, 15'd0, 1'b0, 897, TT_SIX);
        run("six_perturb", 4'd6, 1'b0, 1'b0, 3'd0, 15'd0, 1'b1, 897, TT_SIX);

        cfg_write(3'd0, nd(op(0, 1), op(0, 2), op(0, 3)));
        run("n0_clamp", 4'd0, 1'b0, 1'b0, 3'd0, 15'd0, 1'b0, 257, TT_E8);
        cfg_write(3'd7, nd(op(0, 1), op(0, 2), op(0, 3)));
        run("n12_clamp", 4'd12, 1'b0, 1'b0, 3'd0, 15'd0, 1'b0, 1153, TT_E8);

        // Abort a six-node sweep while evaluating pattern 40.
        load_six();
        @(posedge clk); #2;
        num_nodes = 4'd6; out_inv = 1'b0; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (40 * 7 + 2) @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 128'(busy), 128'd0);
        check("abort_done", 128'(done), 128'd0);
        check("abort_tt", tt, 128'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        repeat (20) @(posedge clk);
        run("after_abort", 4'd1, 1'b0, 1'b0, 3'd0, 15'd0, 1'b0, 257, 128'd0);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
